// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: drives datapath enables/selects per state with a timed memory handshake.
// Define JAL_EN to decode OP_JAL into the jump-and-link state; otherwise it is flagged illegal.
module mips_multicycle_ctrl #(
   parameter int              OP_W     = 6,
   parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
   parameter logic [OP_W-1:0] OP_LW    = 6'h23,
   parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
   parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
   parameter logic [OP_W-1:0] OP_BNE   = 6'h05,
   parameter logic [OP_W-1:0] OP_J     = 6'h02,
   parameter logic [OP_W-1:0] OP_ADDI  = 6'h08,
   parameter logic [OP_W-1:0] OP_JAL   = 6'h03,
   parameter int              TMO_W    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            pc_write_cond_n,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            mem_to_reg,
   output logic            ir_write,
   output logic [1:0]      pc_source,
   output logic [1:0]      alu_op,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic            reg_write,
   output logic            reg_dst,
   output logic            link,
   output logic            illegal_op,
   output logic            mem_timeout,
   output logic [3:0]      state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12
`ifdef JAL_EN
      ,
      S_JAL    = 4'd13
`endif
   } state_t;

   localparam logic [TMO_W-1:0] CNT_MAX  = '1;
   // The cycle that would bring the count to CNT_MAX is the last one allowed.
   localparam logic [TMO_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

   state_t           state_q, state_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             waiting;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      waiting         = 1'b0;
      pc_write        = 1'b0;
      pc_write_cond   = 1'b0;
      pc_write_cond_n = 1'b0;
      i_or_d          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_to_reg      = 1'b0;
      ir_write        = 1'b0;
      pc_source       = 2'b00;
      alu_op          = 2'b00;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      reg_write       = 1'b0;
      reg_dst         = 1'b0;
      link            = 1'b0;
      illegal_op      = 1'b0;
      mem_timeout     = 1'b0;

      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            waiting   = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ,
               OP_BNE:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
`ifdef JAL_EN
               OP_JAL:       state_d = S_JAL;
`else
               OP_JAL: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            waiting  = 1'b1;
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            waiting   = 1'b1;
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a       = 1'b1;
            alu_op          = 2'b01;
            pc_source       = 2'b01;
            pc_write_cond   = (op == OP_BEQ);
            pc_write_cond_n = (op == OP_BNE);
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
`ifdef JAL_EN
         S_JAL: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            reg_write = 1'b1;
            link      = 1'b1;
            state_d   = S_FETCH;
         end
`endif
         default: state_d = S_RST;
      endcase

      // Abort a stalled access back to FETCH; a same-cycle mem_ready wins.
      if (waiting && !mem_ready && (cnt_q == CNT_LAST)) begin
         mem_timeout = 1'b1;
         state_d     = S_FETCH;
      end

      if ((state_d != state_q) || mem_timeout)
         cnt_d = '0;
      else if (waiting && !mem_ready && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table, hand sequences for reset/timeout corners,
// and random traffic checked every cycle against an instruction-phase reference model.
module tb_mips_multicycle_ctrl;
   localparam int TMO_W   = 4;
   localparam int TMO_MAX = (1 << TMO_W) - 1;
`ifdef JAL_EN
   localparam bit JAL_ON = 1'b1;
`else
   localparam bit JAL_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'h00;
   logic       mem_ready = 1'b1;
   logic       pc_write, pc_write_cond, pc_write_cond_n, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, link, illegal_op, mem_timeout;
   logic [1:0] pc_source, alu_op, alu_src_b;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.OP_W(6), .TMO_W(TMO_W)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_n(pc_write_cond_n),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst), .link(link),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
   );

   typedef struct packed {
      logic       pcw, pcwc, pcwcn, iord, mrd, mwr, m2r, irw;
      logic [1:0] pcsrc, aluop;
      logic       srca;
      logic [1:0] srcb;
      logic       rw, rdst, lnk, ill, tmo;
      logic [3:0] st;
   } ctl_t;

   ctl_t act;
   assign act = '{pc_write, pc_write_cond, pc_write_cond_n, i_or_d, mem_read, mem_write,
                  mem_to_reg, ir_write, pc_source, alu_op, alu_src_a, alu_src_b,
                  reg_write, reg_dst, link, illegal_op, mem_timeout, state};

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // Reference model: an instruction is FETCH, DECODE, then a per-opcode list of phases.
   int m_cur   = 0;
   int m_wait  = 0;
   bit m_valid = 1'b0;
   int m_path[$];

   function automatic bit legal(input logic [5:0] o);
      return (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) ||
             (o == 6'h05) || (o == 6'h02) || (o == 6'h08) || (JAL_ON && (o == 6'h03));
   endfunction

   function automatic bit is_wait(input int s);
      return (s == 1) || (s == 4) || (s == 6);
   endfunction

   function automatic ctl_t model_out(input int st, input logic [5:0] o, input logic rdy,
                                      input int waited);
      ctl_t c;
      c = '0;
      c.st = 4'(st);
      case (st)
         1:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
         2:  begin c.srcb = 2'b11; c.ill = !legal(o); end
         3:  begin c.srca = 1; c.srcb = 2'b10; end
         4:  begin c.mrd = 1; c.iord = 1; end
         5:  begin c.m2r = 1; c.rw = 1; end
         6:  begin c.mwr = 1; c.iord = 1; end
         7:  begin c.srca = 1; c.aluop = 2'b10; end
         8:  begin c.rdst = 1; c.rw = 1; end
         9:  begin c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                   c.pcwc = (o == 6'h04); c.pcwcn = (o == 6'h05); end
         10: begin c.pcw = 1; c.pcsrc = 2'b10; end
         11: begin c.srca = 1; c.srcb = 2'b10; end
         12: begin c.rw = 1; end
         13: begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.lnk = 1; end
         default: ;
      endcase
      if (is_wait(st) && !rdy && (waited + 1 >= TMO_MAX)) c.tmo = 1'b1;
      return c;
   endfunction

   task automatic plan(input logic [5:0] o);
      m_path.delete();
      case (o)
         6'h00: begin m_path.push_back(7); m_path.push_back(8); end
         6'h23: begin m_path.push_back(3); m_path.push_back(4); m_path.push_back(5); end
         6'h2B: begin m_path.push_back(3); m_path.push_back(6); end
         6'h04, 6'h05: m_path.push_back(9);
         6'h02: m_path.push_back(10);
         6'h08: begin m_path.push_back(11); m_path.push_back(12); end
         6'h03: if (JAL_ON) m_path.push_back(13);
         default: ;
      endcase
   endtask

   task automatic go(input int s);
      m_cur  = s;
      m_wait = 0;
   endtask

   task automatic next_phase();
      if (m_path.size() > 0) go(m_path.pop_front());
      else go(1);
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         go(0);
         m_path.delete();
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_cur == 0) go(1);
         else if (is_wait(m_cur)) begin
            if (mem_ready) begin
               if (m_cur == 1) go(2);
               else next_phase();
            end else if (m_wait + 1 >= TMO_MAX) begin
               m_path.delete();
               go(1);
            end else m_wait++;
         end else if (m_cur == 2) begin
            plan(op);
            next_phase();
         end else next_phase();
      end
   end

   always @(negedge clk)
      if (m_valid) check("model", 32'(act), 32'(model_out(m_cur, op, mem_ready, m_wait)));

   task automatic apply(input logic rn, input logic [5:0] o, input logic rdy);
      @(posedge clk);
      #1;
      rst_n = rn; op = o; mem_ready = rdy;
      @(negedge clk);
   endtask

   typedef struct {
      logic       rn;
      logic [5:0] o;
      logic       rdy;
      logic [3:0] st;
      logic       pcw, rw, ill;
   } vec_t;

   vec_t       tbl[20];
   logic [5:0] op_tab[9];
   int         tmo_cnt, pcw_cnt, stall;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b0, 6'h00, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 6'h00, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 6'h00, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 6'h00, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 6'h00, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 6'h00, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 6'h23, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 6'h23, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 6'h23, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 6'h23, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 6'h23, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 6'h23, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 6'h23, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 6'h23, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 6'h05, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 6'h05, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 6'h05, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 6'h03, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 6'h03, 1'b1, 4'd2,  1'b0, 1'b0, !JAL_ON};
      tbl[19] = '{1'b1, 6'h03, 1'b1, JAL_ON ? 4'd13 : 4'd1, 1'b1, JAL_ON, 1'b0};
      op_tab  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h03, 6'h3F};

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].rn, tbl[i].o, tbl[i].rdy);
         check($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
         check($sformatf("tbl%0d.pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
         check($sformatf("tbl%0d.reg_write", i), 32'(reg_write), 32'(tbl[i].rw));
         check($sformatf("tbl%0d.illegal_op", i), 32'(illegal_op), 32'(tbl[i].ill));
      end

      // Reset held for two edges in the middle of an R-type EXEC.
      apply(1'b0, 6'h00, 1'b1);
      apply(1'b0, 6'h00, 1'b1);
      apply(1'b1, 6'h00, 1'b1);
      apply(1'b1, 6'h00, 1'b1);
      apply(1'b1, 6'h00, 1'b1);
      apply(1'b0, 6'h00, 1'b1);
      check("rst.mid_exec", 32'(state), 32'd7);
      apply(1'b0, 6'h00, 1'b1);
      check("rst.edge1_all0", 32'(act), 32'd0);
      apply(1'b1, 6'h00, 1'b1);
      check("rst.edge2_all0", 32'(act), 32'd0);
      apply(1'b1, 6'h00, 1'b1);
      check("rst.release_fetch", 32'(state), 32'd1);

      // FETCH starved for the full timeout window.
      apply(1'b0, 6'h00, 1'b0);
      apply(1'b1, 6'h00, 1'b0);
      tmo_cnt = 0;
      pcw_cnt = 0;
      for (int i = 0; i < TMO_MAX; i++) begin
         apply(1'b1, 6'h00, 1'b0);
         tmo_cnt += int'(mem_timeout);
         pcw_cnt += int'(pc_write);
      end
      check("tmo.fetch_pulses", 32'(tmo_cnt), 32'd1);
      check("tmo.fetch_pc_write", 32'(pcw_cnt), 32'd0);
      check("tmo.last_cycle_pulse", 32'(mem_timeout), 32'd1);
      apply(1'b1, 6'h2B, 1'b0);
      check("tmo.back_in_fetch", 32'(state), 32'd1);
      check("tmo.counter_restarted", 32'(mem_timeout), 32'd0);

      // mem_ready on the final allowed wait cycle completes the fetch.
      tmo_cnt = 0;
      for (int i = 0; i < TMO_MAX - 2; i++) begin
         apply(1'b1, 6'h2B, 1'b0);
         tmo_cnt += int'(mem_timeout);
      end
      apply(1'b1, 6'h2B, 1'b1);
      tmo_cnt += int'(mem_timeout);
      check("race.no_timeout", 32'(tmo_cnt), 32'd0);
      check("race.pc_write", 32'(pc_write), 32'd1);
      apply(1'b1, 6'h2B, 1'b0);
      check("race.decode", 32'(state), 32'd2);

      // Store stalled in MEMWR until abort.
      apply(1'b1, 6'h2B, 1'b0);
      check("sw.memadr", 32'(state), 32'd3);
      tmo_cnt = 0;
      for (int i = 0; i < TMO_MAX; i++) begin
         apply(1'b1, 6'h2B, 1'b0);
         check($sformatf("sw.memwr%0d", i), 32'(state), 32'd6);
         tmo_cnt += int'(mem_timeout);
      end
      check("sw.tmo_pulses", 32'(tmo_cnt), 32'd1);
      apply(1'b1, 6'h2B, 1'b1);
      check("sw.abort_to_fetch", 32'(state), 32'd1);

      // Random traffic with occasional long stalls and resets.
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
         logic       rn, rdy;
         logic [5:0] o;
         rn = ($urandom_range(0, 127) != 0);
         o  = op;
         if ((m_cur <= 1) && ($urandom_range(0, 1) == 1)) begin
            o = op_tab[$urandom_range(0, 8)];
            if (o == 6'h3F) o = 6'($urandom_range(0, 63));
         end
         if (stall > 0) begin
            rdy = 1'b0;
            stall--;
         end else begin
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) stall = $urandom_range(10, 17);
         end
         apply(rn, o, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
